// File: rtl/reg_ring_master.sv
// Register-ring master: bridges a valid/ready host command port onto a
// req/ack register ring with per-transaction timeout.
module reg_ring_master #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd_wr_L,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              reg_req_out,
  output logic              reg_rd_wr_L_out,
  output logic [ADDR_W-1:0] reg_addr_out,
  output logic [DATA_W-1:0] reg_wr_data_out,
  input  logic              reg_ack_in,
  input  logic [DATA_W-1:0] reg_rd_data_in,
  output logic              busy,
  output logic [15:0]       timeout_count
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, GAP} state_t;

  state_t state, state_n;
  logic [15:0] wait_cnt, wait_d, tcnt_d;
  logic accept, ack_hit, to_hit, req_wait, consume;
  logic req_d, rdwr_d, vld_d, to_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdat_d, rdat_d;

  assign accept   = (state == IDLE) && cmd_valid;
  assign ack_hit  = (state == REQ) && reg_ack_in;
  assign to_hit   = (state == REQ) && !reg_ack_in
                  && (wait_cnt == 16'(TIMEOUT - 1));
  assign req_wait = (state == REQ) && !reg_ack_in && !to_hit;
  assign consume  = (state == RSP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_n = REQ;
      REQ:     if (ack_hit || to_hit) state_n = RSP;
      RSP:     if (rsp_ready) state_n = GAP;
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values for every registered output; the cases are disjoint.
  always_comb begin
    req_d  = reg_req_out;
    rdwr_d = reg_rd_wr_L_out;
    addr_d = reg_addr_out;
    wdat_d = reg_wr_data_out;
    vld_d  = rsp_valid;
    rdat_d = rsp_data;
    to_d   = rsp_timeout;
    wait_d = wait_cnt;
    tcnt_d = timeout_count;
    unique case (1'b1)
      accept: begin
        req_d  = 1'b1;
        rdwr_d = cmd_rd_wr_L;
        addr_d = cmd_addr;
        wdat_d = cmd_wr_data;
        wait_d = '0;
      end
      ack_hit: begin
        req_d  = 1'b0;
        vld_d  = 1'b1;
        rdat_d = reg_rd_wr_L_out ? reg_rd_data_in : '0;
        to_d   = 1'b0;
      end
      to_hit: begin
        req_d  = 1'b0;
        vld_d  = 1'b1;
        rdat_d = TIMEOUT_DATA;
        to_d   = 1'b1;
        if (timeout_count != 16'hFFFF)
          tcnt_d = timeout_count + 16'd1;
      end
      req_wait: wait_d = wait_cnt + 16'd1;
      consume:  vld_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready       <= 1'b1;
      busy            <= 1'b0;
      reg_req_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_wr_data_out <= '0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_timeout     <= 1'b0;
      wait_cnt        <= '0;
      timeout_count   <= '0;
    end else begin
      cmd_ready       <= (state_n == IDLE);
      busy            <= (state_n != IDLE);
      reg_req_out     <= req_d;
      reg_rd_wr_L_out <= rdwr_d;
      reg_addr_out    <= addr_d;
      reg_wr_data_out <= wdat_d;
      rsp_valid       <= vld_d;
      rsp_data        <= rdat_d;
      rsp_timeout     <= to_d;
      wait_cnt        <= wait_d;
      timeout_count   <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_reg_ring_master.sv
// Bench for reg_ring_master: vector table, hand sequences for
// back-pressure and mid-transaction reset, and a random run vs a model.
module tb_reg_ring_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_rd_wr_L;
  logic [22:0] cmd_addr;
  logic [31:0] cmd_wr_data;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_data;
  logic        reg_req_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_wr_data_out;
  logic        reg_ack_in;
  logic [31:0] reg_rd_data_in;
  logic        busy;
  logic [15:0] timeout_count;

  reg_ring_master #(
    .ADDR_W(23), .DATA_W(32), .TIMEOUT(TMO),
    .TIMEOUT_DATA(32'hDEAD_0000)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd_wr_L(cmd_rd_wr_L), .cmd_addr(cmd_addr),
    .cmd_wr_data(cmd_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .reg_req_out(reg_req_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_wr_data_out(reg_wr_data_out),
    .reg_ack_in(reg_ack_in), .reg_rd_data_in(reg_rd_data_in),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int tc_model = 0;

  typedef struct {
    logic        rd;
    logic [22:0] addr;
    logic [31:0] wd;
    int          dly;
    logic [31:0] rdat;
    int          hold;
    int          e_cyc;
    logic [31:0] e_data;
    logic        e_to;
    logic [15:0] e_tc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level outcome of one transaction: ack in REQ cycle 1..TMO wins,
  // anything else times out after TMO request cycles.
  task automatic model(input logic rd, input int dly,
                       input logic [31:0] rdat, output int cyc,
                       output logic [31:0] d, output logic to);
    if (dly >= 1 && dly <= TMO) begin
      cyc = dly;
      d   = rd ? rdat : 32'h0;
      to  = 1'b0;
    end else begin
      cyc = TMO;
      d   = 32'hDEAD_0000;
      to  = 1'b1;
      if (tc_model < 65535) tc_model++;
    end
  endtask

  task automatic run_txn(input string tag, input logic rd,
                         input logic [22:0] a, input logic [31:0] wd,
                         input int dly, input logic [31:0] rdat,
                         input int hold, input int e_cyc,
                         input logic [31:0] e_data, input logic e_to,
                         input logic [15:0] e_tc);
    int cyc;
    logic stable, rs;
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_rd_wr_L = rd;
    cmd_addr = a;
    cmd_wr_data = wd;
    tick();
    cmd_valid = 1'b0;
    cmd_addr = 23'($urandom);
    cmd_wr_data = $urandom;
    cyc = 0;
    stable = 1'b1;
    while (reg_req_out === 1'b1 && cyc < 100) begin
      cyc++;
      stable &= (reg_addr_out == a) && (reg_wr_data_out == wd)
              && (reg_rd_wr_L_out == rd) && !cmd_ready && busy;
      reg_ack_in = (cyc == dly);
      reg_rd_data_in = (cyc == dly) ? rdat : $urandom;
      tick();
    end
    reg_ack_in = 1'b0;
    chk({tag, " req_cycles"}, 64'(cyc), 64'(e_cyc));
    chk({tag, " ring_stable"}, 64'(stable), 64'(1));
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1));
    chk({tag, " rsp_data"}, 64'(rsp_data), 64'(e_data));
    chk({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'(e_to));
    chk({tag, " timeout_count"}, 64'(timeout_count), 64'(e_tc));
    rsp_ready = 1'b0;
    rs = 1'b1;
    for (int i = 0; i < hold; i++) begin
      reg_ack_in = 1'($urandom);
      tick();
      rs &= rsp_valid && (rsp_data == e_data) && (rsp_timeout == e_to)
          && !cmd_ready && !reg_req_out;
    end
    reg_ack_in = 1'b0;
    chk({tag, " rsp_hold"}, 64'(rs), 64'(1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, " gap"},
        64'({rsp_valid, reg_req_out, cmd_ready, busy}), 64'(4'b0001));
    reg_ack_in = 1'($urandom);
    tick();
    reg_ack_in = 1'b0;
    chk({tag, " idle"},
        64'({rsp_valid, reg_req_out, cmd_ready, busy}), 64'(4'b0010));
  endtask

  initial begin
    int cyc;
    logic [31:0] d;
    logic to, ok, rd;
    logic [22:0] a;
    logic [31:0] wd, rdat;
    int dly;

    vecs[0] = '{1'b0, 23'h400441, 32'h1234_5678, 1, 32'hAAAA_5555, 0,
                1, 32'h0, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 23'h400442, 32'h0, 5, 32'hCAFE_F00D, 2,
                5, 32'hCAFE_F00D, 1'b0, 16'd0};
    vecs[2] = '{1'b1, 23'h400443, 32'h0, 0, 32'h1111_2222, 1,
                8, 32'hDEAD_0000, 1'b1, 16'd1};
    vecs[3] = '{1'b1, 23'h400444, 32'h0, 8, 32'h0BAD_BEEF, 0,
                8, 32'h0BAD_BEEF, 1'b0, 16'd1};
    vecs[4] = '{1'b0, 23'h400445, 32'h5555_AAAA, 9, 32'h0, 3,
                8, 32'hDEAD_0000, 1'b1, 16'd2};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_rd_wr_L = 1'b0;
    cmd_addr = '0;
    cmd_wr_data = '0;
    rsp_ready = 1'b0;
    reg_ack_in = 1'b0;
    reg_rd_data_in = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst ring", 64'({reg_req_out, reg_rd_wr_L_out, reg_addr_out,
        reg_wr_data_out}), 64'(0));
    chk("rst rsp", 64'({rsp_valid, rsp_timeout, rsp_data}), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst tcount", 64'(timeout_count), 64'(0));

    reg_ack_in = 1'b1;
    reg_rd_data_in = 32'h1357_9BDF;
    tick();
    tick();
    reg_ack_in = 1'b0;
    chk("idle ack ignored",
        64'({rsp_valid, reg_req_out, busy, cmd_ready}), 64'(4'b0001));

    for (int i = 0; i < 5; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr,
              vecs[i].wd, vecs[i].dly, vecs[i].rdat, vecs[i].hold,
              vecs[i].e_cyc, vecs[i].e_data, vecs[i].e_to, vecs[i].e_tc);
    end
    tc_model = 2;

    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom);
      a = 23'($urandom);
      wd = $urandom;
      rdat = $urandom;
      dly = int'($urandom_range(0, 10));
      model(rd, dly, rdat, cyc, d, to);
      run_txn($sformatf("rnd%0d", i), rd, a, wd, dly, rdat,
              int'($urandom_range(0, 3)), cyc, d, to, 16'(tc_model));
    end

    // Back-pressure: response held while a new command waits.
    cmd_valid = 1'b1;
    cmd_rd_wr_L = 1'b1;
    cmd_addr = 23'h00_1234;
    tick();
    reg_ack_in = 1'b1;
    reg_rd_data_in = 32'hFACE_B00C;
    cmd_addr = 23'h00_5678;
    cmd_wr_data = 32'h9999_0000;
    cmd_rd_wr_L = 1'b0;
    tick();
    reg_ack_in = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ok &= rsp_valid && (rsp_data == 32'hFACE_B00C) && !cmd_ready
          && !reg_req_out;
      tick();
    end
    chk("bp hold", 64'(ok), 64'(1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp gap", 64'({reg_req_out, cmd_ready, rsp_valid}), 64'(0));
    tick();
    chk("bp idle", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    chk("bp next req", 64'({reg_req_out, reg_addr_out, reg_rd_wr_L_out}),
        64'({1'b1, 23'h00_5678, 1'b0}));
    reg_ack_in = 1'b1;
    tick();
    reg_ack_in = 1'b0;
    chk("bp write rsp", 64'({rsp_valid, rsp_data}), 64'({1'b1, 32'h0}));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    // Reset in the middle of a request.
    cmd_valid = 1'b1;
    cmd_rd_wr_L = 1'b1;
    cmd_addr = 23'h00_0777;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid req", 64'(reg_req_out), 64'(1));
    reset = 1'b1;
    tick();
    chk("rst req drop", 64'({reg_req_out, rsp_valid, busy}), 64'(0));
    chk("rst tc clr", 64'(timeout_count), 64'(0));
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reg_ack_in = 1'($urandom);
      tick();
      ok &= !rsp_valid && !reg_req_out && cmd_ready;
    end
    reg_ack_in = 1'b0;
    chk("post rst quiet", 64'(ok), 64'(1));
    tc_model = 0;
    model(1'b1, 0, 32'h0, cyc, d, to);
    run_txn("post rst", 1'b1, 23'h7F_FFFF, 32'h0, 0, 32'h0, 1,
            cyc, d, to, 16'(tc_model));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/reg_ring_master.md
REG_RING_MASTER -- requirements
Module: reg_ring_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, register-ring address width.
REQ-002 SHALL have parameter DATA_W, default 32, register-ring data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles in REQ without ack (range 1..65535).
REQ-004 SHALL have parameter TIMEOUT_DATA, default 32'hDEAD_0000, rsp_data value on timeout.
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port cmd_valid  input  1  host command present.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
REQ-009 SHALL have port cmd_rd_wr_L  input  1  1=read, 0=write.
REQ-010 SHALL have port cmd_addr  input  ADDR_W  target register address.
REQ-011 SHALL have port cmd_wr_data  input  DATA_W  write data.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  host consumes response when rsp_valid&rsp_ready.
REQ-014 SHALL have port rsp_data  output  DATA_W  read data, 0 for writes, TIMEOUT_DATA on timeout.
REQ-015 SHALL have port rsp_timeout  output  1  response is a timeout.
REQ-016 SHALL have port reg_req_out  output  1  ring request, held until ack or timeout.
REQ-017 SHALL have port reg_rd_wr_L_out  output  1  ring direction.
REQ-018 SHALL have port reg_addr_out  output  ADDR_W  ring address.
REQ-019 SHALL have port reg_wr_data_out  output  DATA_W  ring write data.
REQ-020 SHALL have port reg_ack_in  input  1  responder acknowledge.
REQ-021 SHALL have port reg_rd_data_in  input  DATA_W  responder read data, valid with reg_ack_in.
REQ-022 SHALL have port busy  output  1  high in any state except IDLE.
REQ-023 SHALL have port timeout_count  output  16  saturating count of timed-out transactions.

Function
REQ-024 SHALL implement FSM states IDLE, REQ, RSP, GAP; all outputs registered.
REQ-025 IDLE: cmd_ready=1; on cmd_valid capture rd_wr_L/addr/wr_data into ring outputs, assert reg_req_out next cycle, go REQ.
REQ-026 cmd_ready SHALL be 1 only in IDLE; one command outstanding at most.
REQ-027 REQ: reg_req_out, reg_rd_wr_L_out, reg_addr_out, reg_wr_data_out SHALL stay stable every cycle until exit.
REQ-028 REQ: 16-bit wait counter cleared on entry, +1 per cycle without ack.
REQ-029 REQ with reg_ack_in=1: next edge drop reg_req_out, rsp_data=reg_rd_data_in (read) or 0 (write), rsp_timeout=0, rsp_valid=1, go RSP.
REQ-030 REQ with counter==TIMEOUT-1 and no ack: next edge drop reg_req_out, rsp_data=TIMEOUT_DATA, rsp_timeout=1, rsp_valid=1, timeout_count+1 (saturate at 16'hFFFF), go RSP.
REQ-031 Ack and timeout in same cycle: ack wins, no timeout recorded.
REQ-032 Earliest ack sampled is the first REQ cycle; minimum cmd-accept to rsp_valid latency is 2 cycles.
REQ-033 RSP: hold rsp_* stable; on rsp_ready clear rsp_valid, go GAP.
REQ-034 GAP: exactly one cycle, reg_req_out=0, ignore reg_ack_in; then IDLE (guarantees responder ack falls before next request).
REQ-035 reg_ack_in outside REQ SHALL be ignored, no state change.
REQ-036 Back-to-back commands: request-to-request spacing min 2 cycles with reg_req_out low between.

Reset
REQ-037 On reset: state IDLE, reg_req_out=0, reg_rd_wr_L_out=0, reg_addr_out=0, reg_wr_data_out=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0, timeout_count=0, wait counter=0.
REQ-038 Reset mid-transaction SHALL discard the command, drop reg_req_out at that edge, emit no response.

Verification
REQ-039 Write addr 23'h400441 data 32'h1234_5678, responder acks 1 cycle later -> req held 1 cycle, rsp_valid with rsp_data=0, rsp_timeout=0.
REQ-040 Read addr 23'h400442, ack after 5 cycles with data 32'hCAFE_F00D -> req stable 5 cycles, rsp_data=32'hCAFE_F00D.
REQ-041 Read, no ack, TIMEOUT=8 -> req drops after 8 cycles, rsp_data=32'hDEAD_0000, rsp_timeout=1, timeout_count=1.
REQ-042 Ack on the TIMEOUT-th cycle -> normal response, timeout_count unchanged.
REQ-043 rsp_ready held 0 for 10 cycles with cmd_valid=1 -> cmd_ready=0, rsp stable; after consume, GAP 1 cycle, next req asserted.
REQ-044 Reset asserted in REQ -> reg_req_out=0 next edge, no rsp_valid, cmd_ready=1 after reset release.
